// File: rtl/seven_seg_top.sv
// -----------------------------------------------------------------------------
// seven_seg_top
//   Board-level seven-segment driver for one common-anode digit. Two switches
//   pick a display mode, the remaining eight supply two 4-bit operands, and
//   the decoded glyph is registered before it drives the segments.
//
//   Modes (SW[9:8]):
//     00  operand A (SW[3:0]) as a hex digit
//     01  operand B (SW[7:4]) as a hex digit
//     10  (A + B) mod 16 as a hex digit
//     11  A as a decimal digit, "E" for 10-15
//
// Ports
//   clk  in   1   system clock, rising edge
//   rst  in   1   synchronous active-high reset
//   SW   in  10   mode and operands
//   hex  out  7   segments, active-low, hex[0]=a ... hex[6]=g
//
// Configuration
//   SEG7_SYNC_EN  when defined, SW passes through a 2-flop synchronizer before
//                 decode (SW-to-hex latency 3 cycles instead of 1).
// -----------------------------------------------------------------------------
module seven_seg_top (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  output logic [6:0] hex
);

  // Switch bus as seen by the decode logic
  logic [9:0] sw_dec;

`ifdef SEG7_SYNC_EN
  logic [9:0] sync_a;
  logic [9:0] sync_b;

  // Two-stage synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= SW;
      sync_b <= sync_a;
    end
  end

  assign sw_dec = sync_b;
`else
  assign sw_dec = SW;
`endif

  logic [1:0] mode;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [3:0] value;
  logic       dec_err;
  logic [6:0] glyph;

  assign mode = sw_dec[9:8];
  assign opa  = sw_dec[3:0];
  assign opb  = sw_dec[7:4];

  // Mode select; the 4-bit adder drops its carry so the sum wraps mod 16
  always_comb begin
    value   = opa;
    dec_err = 1'b0;
    unique case (mode)
      2'b00: value = opa;
      2'b01: value = opb;
      2'b10: value = opa + opb;
      2'b11: begin
        value   = opa;
        dec_err = (opa > 4'd9);
      end
    endcase
  end

  // Active-low glyph table; lowercase b and d keep them distinct from 8 and 0
  always_comb begin
    glyph = 7'h7F;
    if (dec_err) begin
      glyph = 7'h06;
    end else begin
      unique case (value)
        4'h0: glyph = 7'h40;
        4'h1: glyph = 7'h79;
        4'h2: glyph = 7'h24;
        4'h3: glyph = 7'h30;
        4'h4: glyph = 7'h19;
        4'h5: glyph = 7'h12;
        4'h6: glyph = 7'h02;
        4'h7: glyph = 7'h78;
        4'h8: glyph = 7'h00;
        4'h9: glyph = 7'h10;
        4'hA: glyph = 7'h08;
        4'hB: glyph = 7'h03;
        4'hC: glyph = 7'h46;
        4'hD: glyph = 7'h21;
        4'hE: glyph = 7'h06;
        4'hF: glyph = 7'h0E;
      endcase
    end
  end

  // Output register; reset blanks the digit
  always_ff @(posedge clk) begin
    if (rst) begin
      hex <= 7'h7F;
    end else begin
      hex <= glyph;
    end
  end

endmodule

// File: tb/tb_seven_seg_top.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_top
//   Self-checking bench for seven_seg_top. Directed vectors per mode, reset
//   behaviour, SW-to-hex latency, and a full sweep of all 1024 switch settings
//   against an independent reference model. Honours SEG7_SYNC_EN for latency.
// -----------------------------------------------------------------------------
module tb_seven_seg_top;

`ifdef SEG7_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] SW;
  logic [6:0] hex;

  int checks;
  int failures;

  seven_seg_top dut (
    .clk (clk),
    .rst (rst),
    .SW  (SW),
    .hex (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph for a value 0-15
  function automatic logic [6:0] ref_glyph(input int v);
    case (v)
      0:  return 7'h40;
      1:  return 7'h79;
      2:  return 7'h24;
      3:  return 7'h30;
      4:  return 7'h19;
      5:  return 7'h12;
      6:  return 7'h02;
      7:  return 7'h78;
      8:  return 7'h00;
      9:  return 7'h10;
      10: return 7'h08;
      11: return 7'h03;
      12: return 7'h46;
      13: return 7'h21;
      14: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Reference model of the whole decode for one switch setting
  function automatic logic [6:0] ref_model(input logic [9:0] s);
    int a, b, m;
    a = int'(s[3:0]);
    b = int'(s[7:4]);
    m = int'(s[9:8]);
    if (m == 0) return ref_glyph(a);
    if (m == 1) return ref_glyph(b);
    if (m == 2) return ref_glyph((a + b) % 16);
    if (a >= 10) return 7'h06;
    return ref_glyph(a);
  endfunction

  // Advance n rising edges, then settle just past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    SW  = 10'b10_1010_0111;
    step(1);
    checks++;
    if (hex !== 7'h7F) begin
      failures++;
      $display("[TB] FAIL reset_1 hex=%h expected=%h", hex, 7'h7F);
    end
    SW = 10'b00_0000_0011;
    step(1);
    checks++;
    if (hex !== 7'h7F) begin
      failures++;
      $display("[TB] FAIL reset_2 hex=%h expected=%h", hex, 7'h7F);
    end
    rst = 1'b0;
    step(LAT);
    checks++;
    if (hex !== 7'h30) begin
      failures++;
      $display("[TB] FAIL reset_release hex=%h expected=%h", hex, 7'h30);
    end
  endtask

  task automatic test_mode_hex_a();
    logic [9:0] sw_vec [3];
    logic [6:0] exp_vec [3];
    sw_vec[0] = 10'b00_0000_0000; exp_vec[0] = 7'h40;
    sw_vec[1] = 10'b00_0000_0101; exp_vec[1] = 7'h12;
    sw_vec[2] = 10'b00_0000_1011; exp_vec[2] = 7'h03;
    for (int i = 0; i < 3; i++) begin
      SW = sw_vec[i];
      step(LAT);
      checks++;
      if (hex !== exp_vec[i]) begin
        failures++;
        $display("[TB] FAIL mode00_%0d hex=%h expected=%h", i, hex, exp_vec[i]);
      end
    end
  endtask

  task automatic test_mode_hex_b();
    SW = 10'b01_0101_1011;
    step(LAT);
    checks++;
    if (hex !== 7'h12) begin
      failures++;
      $display("[TB] FAIL mode01 hex=%h expected=%h", hex, 7'h12);
    end
    // Operand A must not affect mode 01
    SW = 10'b01_0101_0000;
    step(LAT);
    checks++;
    if (hex !== 7'h12) begin
      failures++;
      $display("[TB] FAIL mode01_ignore_a hex=%h expected=%h", hex, 7'h12);
    end
  endtask

  task automatic test_mode_sum();
    logic [9:0] sw_vec [3];
    logic [6:0] exp_vec [3];
    sw_vec[0] = 10'b10_0101_0000; exp_vec[0] = 7'h12;
    sw_vec[1] = 10'b10_0101_0011; exp_vec[1] = 7'h00;
    sw_vec[2] = 10'b10_0101_1111; exp_vec[2] = 7'h19;
    for (int i = 0; i < 3; i++) begin
      SW = sw_vec[i];
      step(LAT);
      checks++;
      if (hex !== exp_vec[i]) begin
        failures++;
        $display("[TB] FAIL mode10_%0d hex=%h expected=%h", i, hex, exp_vec[i]);
      end
    end
  endtask

  task automatic test_mode_decimal();
    logic [9:0] sw_vec [4];
    logic [6:0] exp_vec [4];
    sw_vec[0] = 10'b11_0000_0000; exp_vec[0] = 7'h40;
    sw_vec[1] = 10'b11_0000_1001; exp_vec[1] = 7'h10;
    sw_vec[2] = 10'b11_0000_1011; exp_vec[2] = 7'h06;
    sw_vec[3] = 10'b11_0000_1010; exp_vec[3] = 7'h06;
    for (int i = 0; i < 4; i++) begin
      SW = sw_vec[i];
      step(LAT);
      checks++;
      if (hex !== exp_vec[i]) begin
        failures++;
        $display("[TB] FAIL mode11_%0d hex=%h expected=%h", i, hex, exp_vec[i]);
      end
    end
  endtask

  task automatic test_latency();
    SW = 10'b00_0000_0001;
    step(LAT + 1);
    SW = 10'b00_0000_0111;
    // Output must still show the old glyph until LAT edges have passed
    for (int i = 0; i < LAT; i++) begin
      checks++;
      if (hex !== 7'h79) begin
        failures++;
        $display("[TB] FAIL latency_hold_%0d hex=%h expected=%h", i, hex, 7'h79);
      end
      step(1);
    end
    checks++;
    if (hex !== 7'h78) begin
      failures++;
      $display("[TB] FAIL latency_update hex=%h expected=%h", hex, 7'h78);
    end
  endtask

  task automatic test_reset_wins();
    SW  = 10'b00_0000_0010;
    step(LAT);
    rst = 1'b1;
    SW  = 10'b00_0000_0100;
    step(1);
    checks++;
    if (hex !== 7'h7F) begin
      failures++;
      $display("[TB] FAIL reset_wins hex=%h expected=%h", hex, 7'h7F);
    end
    rst = 1'b0;
    step(LAT);
    checks++;
    if (hex !== 7'h19) begin
      failures++;
      $display("[TB] FAIL reset_wins_release hex=%h expected=%h", hex, 7'h19);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] expected;
    for (int s = 0; s < 1024; s++) begin
      SW = 10'(s);
      step(LAT);
      expected = ref_model(10'(s));
      checks++;
      if (hex !== expected) begin
        failures++;
        $display("[TB] FAIL sweep SW=%b hex=%h expected=%h", 10'(s), hex, expected);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    SW       = '0;
    step(1);
    test_reset();
    test_mode_hex_a();
    test_mode_hex_b();
    test_mode_sum();
    test_mode_decimal();
    test_latency();
    test_reset_wins();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
